// File: rtl/req_issue_pkg.sv
// req_issue_pkg: shared defaults, tag type and helpers for the request issue queue.
package req_issue_pkg;

  localparam int TAG_W_DEF    = 4;
  localparam int DEPTH_DEF    = 4;
  localparam int MAX_WAIT_DEF = 10;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  // Ceiling of the 4-bit head stall counter.
  localparam logic [3:0] WAIT_SAT = 4'hF;

  // Saturating increment for the 4-bit stall counter.
  function automatic logic [3:0] wait_sat_inc(input logic [3:0] v);
    return (v == WAIT_SAT) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/req_sync_fifo.sv
// req_sync_fifo: circular synchronous FIFO with an explicit occupancy counter.
// The head word reads as zero while empty so downstream never sees stale tags.
module req_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // Qualify requests so a push into a full FIFO or a pop from an empty one is a no-op.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Storage write; contents are not reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap modulo DEPTH through natural overflow (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
    end
  end

  // Occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Status flags and head word decoded from registered state only.
  always_comb begin
    full  = (level == LW'(DEPTH));
    empty = (level == '0);
    rdata = empty ? '0 : mem[rptr];
  end

endmodule

// File: rtl/req_issue_queue.sv
// req_issue_queue: buffers tagged requests and issues them one at a time to a
// downstream countdown counter, tracking how long the head entry is stalled.
// Optional statistics (issue_count, max_wait) are built when REQ_ISSUE_STATS_EN
// is defined; the default build omits those ports and registers.
//
// Handshake semantics: on both sides a transfer happens on a rising clk edge
// where valid and ready are both high (push = req_valid && req_ready,
// pop = valid_out && ready_in). Once valid_out is raised, valid_out and tag_out
// hold steady until the transfer completes; ready may change freely.
module req_issue_queue
  import req_issue_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       req_ready,
  output logic                       valid_out,
  output logic [TAG_W-1:0]           tag_out,
  input  logic                       ready_in,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [3:0]                 wait_cnt,
  output logic                       wait_err
`ifdef REQ_ISSUE_STATS_EN
  ,
  output logic [15:0]                issue_count,
  output logic [3:0]                 max_wait
`endif
);

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       stall;
  logic [3:0] wait_cnt_nxt;
  logic       wait_err_nxt;

  req_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (req_tag),
    .rdata (tag_out),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Handshake decode; outputs depend only on FIFO state, never on req_valid or ready_in.
  always_comb begin
    req_ready = !full;
    valid_out = !empty;
    push      = req_valid && req_ready;
    pop       = valid_out && ready_in;
    stall     = valid_out && !ready_in;
  end

  // Next stall count: cleared on pop or while empty, saturating increment while stalled.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (pop || empty) begin
      wait_cnt_nxt = '0;
    end else if (stall) begin
      wait_cnt_nxt = wait_sat_inc(wait_cnt);
    end
  end

  // Error becomes sticky once the head is still stalled after MAX_WAIT stall cycles.
  always_comb begin
    wait_err_nxt = wait_err;
    if (stall && (wait_cnt == 4'(MAX_WAIT))) begin
      wait_err_nxt = 1'b1;
    end
  end

  // Stall counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      wait_err <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      wait_err <= wait_err_nxt;
    end
  end

`ifdef REQ_ISSUE_STATS_EN
  // Issue counter (wraps at 2^16) and running maximum of the head stall count.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_count <= '0;
      max_wait    <= '0;
    end else begin
      if (pop) issue_count <= issue_count + 16'd1;
      if (wait_cnt > max_wait) max_wait <= wait_cnt;
    end
  end
`else
  // Statistics disabled: no extra ports or registers.
`endif

endmodule

// File: tb/tb_req_issue_queue.sv
// tb_req_issue_queue: directed bench for req_issue_queue with a tag scoreboard
// and a small model of the downstream countdown counter.
module tb_req_issue_queue;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_tag;
  logic       req_ready;
  logic       valid_out;
  logic [3:0] tag_out;
  logic       ready_in;
  logic [2:0] level;
  logic [3:0] wait_cnt;
  logic       wait_err;
`ifdef REQ_ISSUE_STATS_EN
  logic [15:0] issue_count;
  logic [3:0]  max_wait;
`endif

  logic       ready_drv;
  logic       use_ctr;
  logic [3:0] ctr_cnt;
  logic       ctr_ready;

  int checks;
  int failures;
  int sent;
  int guard;
  int stall_tab [5] = '{0, 3, 1, 7, 2};
  logic [11:0] rdy_pat;
  logic [3:0] exp_q [$];

  req_issue_queue dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_tag     (req_tag),
    .req_ready   (req_ready),
    .valid_out   (valid_out),
    .tag_out     (tag_out),
    .ready_in    (ready_in),
    .level       (level),
    .wait_cnt    (wait_cnt),
    .wait_err    (wait_err)
`ifdef REQ_ISSUE_STATS_EN
    ,
    .issue_count (issue_count),
    .max_wait    (max_wait)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream countdown counter model: accepts when idle, then busy for 10 cycles.
  assign ctr_ready = (ctr_cnt == 4'd0);
  assign ready_in  = use_ctr ? ctr_ready : ready_drv;

  always @(posedge clk) begin
    if (rst) ctr_cnt <= 4'd0;
    else if (use_ctr && valid_out && ctr_ready) ctr_cnt <= 4'd10;
    else if (ctr_cnt != 4'd0) ctr_cnt <= ctr_cnt - 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: record accepted pushes, compare every pop against the oldest entry.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) check("pop_unexpected", valid_out, 0);
        else check("pop_tag", tag_out, exp_q.pop_front());
      end
      if (req_valid && req_ready) exp_q.push_back(req_tag);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] tag);
    req_valid = 1'b1;
    req_tag   = tag;
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    ready_drv = 1'b1;
    for (int n = 0; n < 40 && level != 3'd0; n++) step();
    check("drain_level", level, 0);
    check("drain_sb_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 1'b1;
    req_tag   = 4'hF;
    ready_drv = 1'b1;
    use_ctr   = 1'b0;
    rdy_pat   = 12'b1011_0111_0110;

    // Reset with push and pop requested: reset values must win.
    step();
    step();
    check("rst_req_ready", req_ready, 1);
    check("rst_valid_out", valid_out, 0);
    check("rst_tag_out", tag_out, 0);
    check("rst_level", level, 0);
    check("rst_wait_cnt", wait_cnt, 0);
    check("rst_wait_err", wait_err, 0);
    rst       = 1'b0;
    req_valid = 1'b0;

    // Fill to full, refuse a fifth push, then drain in order.
    ready_drv = 1'b0;
    push_one(4'd1);
    check("first_valid", valid_out, 1);
    check("first_tag", tag_out, 1);
    push_one(4'd2);
    push_one(4'd3);
    push_one(4'd4);
    check("full_level", level, 4);
    check("full_req_ready", req_ready, 0);
    req_valid = 1'b1;
    req_tag   = 4'd5;
    step();
    check("full_refuse_level", level, 4);
    check("full_head_stable", tag_out, 1);
    ready_drv = 1'b1;
    step();
    check("after_pop_level", level, 3);
    check("after_pop_ready", req_ready, 1);
    check("after_pop_tag", tag_out, 2);
    step();
    req_valid = 1'b0;
    check("push5_level", level, 3);
    check("push5_head", tag_out, 3);
    drain();

    // Stall bound: wait_cnt counts 0..10, error sets on the 11th stall cycle.
    ready_drv = 1'b0;
    push_one(4'd7);
    for (int i = 0; i <= 10; i++) begin
      check("stall_wait_cnt", wait_cnt, i);
      check("stall_err_low", wait_err, 0);
      check("stall_tag", tag_out, 7);
      step();
    end
    check("stall_err_set", wait_err, 1);
    check("stall_wait_cnt_11", wait_cnt, 11);
    ready_drv = 1'b1;
    step();
    check("err_sticky_pop", wait_err, 1);
    check("wait_cnt_clear", wait_cnt, 0);
    check("empty_after_pop", valid_out, 0);
    step();
    check("err_sticky_idle", wait_err, 1);
    do_reset();
    check("err_cleared_rst", wait_err, 0);

    // Simultaneous push and pop at level 2.
    ready_drv = 1'b0;
    push_one(4'd8);
    push_one(4'd9);
    check("pp_level_before", level, 2);
    req_valid = 1'b1;
    req_tag   = 4'd10;
    ready_drv = 1'b1;
    step();
    req_valid = 1'b0;
    check("pp_level_same", level, 2);
    check("pp_head", tag_out, 9);
    step();
    check("pp_new_third", tag_out, 10);
    drain();

    // Pointer wrap across 3 x DEPTH pushes with a varying ready pattern.
    sent  = 0;
    guard = 0;
    while (sent < 12 && guard < 100) begin
      ready_drv = rdy_pat[guard % 12];
      req_valid = 1'b1;
      req_tag   = 4'(sent + 3);
      if (req_ready) sent++;
      step();
      guard++;
    end
    req_valid = 1'b0;
    check("wrap_sent", sent, 12);
    drain();

    // Against the countdown counter: second request stalls exactly 10 cycles.
    use_ctr   = 1'b1;
    req_valid = 1'b1;
    req_tag   = 4'hA;
    step();
    check("ctr_first_tag", tag_out, 4'hA);
    req_tag = 4'hB;
    step();
    req_valid = 1'b0;
    check("ctr_second_tag", tag_out, 4'hB);
    check("ctr_level", level, 1);
    for (int k = 0; k < 10; k++) begin
      check("ctr_not_ready", ready_in, 0);
      check("ctr_valid_hold", valid_out, 1);
      check("ctr_tag_hold", tag_out, 4'hB);
      check("ctr_wait_cnt", wait_cnt, k);
      check("ctr_err_low", wait_err, 0);
      step();
    end
    check("ctr_ready_again", ready_in, 1);
    check("ctr_wait_cnt_10", wait_cnt, 10);
    step();
    check("ctr_done_level", level, 0);
    check("ctr_err_final", wait_err, 0);
    use_ctr = 1'b0;

`ifdef REQ_ISSUE_STATS_EN
    // Statistics: five pops with stalls of 0, 3, 1, 7, 2.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ready_drv = 1'b0;
      push_one(4'(k + 1));
      for (int s = 0; s < stall_tab[k]; s++) step();
      check("stats_wait_at_pop", wait_cnt, stall_tab[k]);
      ready_drv = 1'b1;
      step();
    end
    step();
    check("stats_issue_count", issue_count, 5);
    check("stats_max_wait", max_wait, 7);
`endif

    // Reset mid-operation with push and pop requested.
    ready_drv = 1'b0;
    push_one(4'd1);
    push_one(4'd2);
    push_one(4'd3);
    check("mid_level", level, 3);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_tag   = 4'hC;
    ready_drv = 1'b1;
    step();
    rst       = 1'b0;
    req_valid = 1'b0;
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_tag", tag_out, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_wait", wait_cnt, 0);
    step();
    check("mid_rst_idle_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends with a summary.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
